rgb_hue_fader: RTL and testbench

RGB_HUE_FADER -- requirements
Module: rgb_hue_fader

---
 rtl/rgb_hue_fader.sv | 231 +++++++++++++++++++++++
 tb/tb_rgb_hue_fader.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_hue_fader.sv
// ----------------------------------------------------------------------------
// rgb_hue_fader
//
// Walks an RGB LED around the hue wheel by slowly ramping one colour channel
// at a time. It produces three 8-bit duty values for a downstream PWM stage.
// A prescaler divides clk down to "fade steps" (ticks). On every tick the
// channel that is currently ramping moves by STEP. When that channel reaches
// its rail (255 when ramping up, 0 when ramping down), the wheel advances to
// the next of its six phases:
//
//   phase | held channels | ramping channel
//   ------+---------------+----------------
//     0   | R=255, B=0    | G up
//     1   | G=255, B=0    | R down
//     2   | G=255, R=0    | B up
//     3   | B=255, R=0    | G down
//     4   | B=255, G=0    | R up
//     5   | R=255, G=0    | B down
//
// Because only one channel ramps in each phase, at most one channel is ever
// strictly between 0 and 255.
//
// Parameters
//   TICK_DIV : clk cycles per fade step, 1..2^24 (1 = every enabled cycle)
//   STEP     : duty change per fade step, 1..255
//
// Ports
//   clk      in   system clock, rising-edge
//   nrst     in   asynchronous active-low reset
//   en       in   1 = prescaler runs and fading advances, 0 = all state frozen
//   restart  in   synchronous return to the reset state, overrides en
//   duty_r   out  [7:0] red duty cycle
//   duty_g   out  [7:0] green duty cycle
//   duty_b   out  [7:0] blue duty cycle
//   phase    out  [2:0] current hue-wheel phase, 0..5
//   wrap     out  one-cycle pulse after the tick that moves phase 5 -> 0
//
// Every output comes straight from a flop. There is no combinational path
// from any input to any output.
// ----------------------------------------------------------------------------
module rgb_hue_fader #(
    parameter int TICK_DIV = 100000,
    parameter int STEP     = 1
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       en,
    input  logic       restart,
    output logic [7:0] duty_r,
    output logic [7:0] duty_g,
    output logic [7:0] duty_b,
    output logic [2:0] phase,
    output logic       wrap
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // The prescaler counts 0..TICK_DIV-1. With TICK_DIV=1 the counter stays
    // at 0, so every enabled cycle is a tick. It still needs at least one bit.
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    // Ramp arithmetic uses 9 bits, so an up-ramp that overshoots 255 shows
    // up in bit 8 and never silently wraps back around to a small value.
    localparam logic [8:0] STEP9 = 9'(STEP);
    localparam logic [7:0] STEP8 = 8'(STEP);

    // Channel indices into the packed duty vector.
    localparam logic [1:0] CH_R = 2'd0;
    localparam logic [1:0] CH_G = 2'd1;
    localparam logic [1:0] CH_B = 2'd2;

    // Reset colour is pure red: {B, G, R} = {0, 0, 255}.
    localparam logic [2:0][7:0] DUTY_RST = {8'd0, 8'd0, 8'd255};

    // Each phase is named after its held rail, the ramping channel and the
    // ramp direction.
    typedef enum logic [2:0] {
        PH_R_G_UP = 3'd0,
        PH_G_R_DN = 3'd1,
        PH_G_B_UP = 3'd2,
        PH_B_G_DN = 3'd3,
        PH_B_R_UP = 3'd4,
        PH_R_B_DN = 3'd5
    } phase_t;

    // ------------------------------------------------------------------------
    // State and next-state signals
    // ------------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_reg,  cnt_next;
    logic [2:0][7:0]  duty_reg, duty_next;
    phase_t           phase_reg, phase_next;
    logic             wrap_reg, wrap_next;

    // Decoded from the current phase.
    logic [1:0]       ramp_sel;     // which channel is ramping
    logic             ramp_up;      // 1 = ramping toward 255
    logic             phase_legal;  // 0 for the unreachable encodings 6/7

    // Per-channel ramp results, as if a tick happened this cycle.
    logic [2:0][7:0]  chan_val;     // candidate duty after the tick
    logic [2:0]       chan_done;    // ramping channel hit its rail
    logic             advance;      // phase moves on with this tick
    logic             tick;         // prescaler terminal count

    // ------------------------------------------------------------------------
    // Phase decode: which channel ramps and in which direction.
    // Even phases ramp up and odd phases ramp down. The ramping channel
    // cycles G, R, B, G, R, B around the wheel.
    // ------------------------------------------------------------------------
    always_comb begin
        ramp_sel    = CH_G;
        ramp_up     = 1'b1;
        phase_legal = 1'b1;
        case (phase_reg)
            PH_R_G_UP: begin ramp_sel = CH_G; ramp_up = 1'b1; end
            PH_G_R_DN: begin ramp_sel = CH_R; ramp_up = 1'b0; end
            PH_G_B_UP: begin ramp_sel = CH_B; ramp_up = 1'b1; end
            PH_B_G_DN: begin ramp_sel = CH_G; ramp_up = 1'b0; end
            PH_B_R_UP: begin ramp_sel = CH_R; ramp_up = 1'b1; end
            PH_R_B_DN: begin ramp_sel = CH_B; ramp_up = 1'b0; end
            default: begin
                // 6/7 cannot be reached through normal stepping. If one ever
                // appears (upset, bad init), the next tick forces reset state.
                ramp_sel    = CH_G;
                ramp_up     = 1'b1;
                phase_legal = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Per-channel saturating ramp.
    // Only the selected channel moves. The others pass through unchanged.
    // Up:   ch + STEP >= 255  -> 255 and done   (same as ch >= 255 - STEP)
    // Down: ch <= STEP        -> 0   and done
    // ------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_chan
            logic [8:0] up_sum;
            logic       sel_hit;
            logic       up_sat;
            logic       dn_sat;

            assign up_sum  = {1'b0, duty_reg[gi]} + STEP9;
            assign sel_hit = (ramp_sel == 2'(gi));
            assign up_sat  = (up_sum >= 9'd255);
            assign dn_sat  = ({1'b0, duty_reg[gi]} <= STEP9);

            assign chan_done[gi] = sel_hit & (ramp_up ? up_sat : dn_sat);

            assign chan_val[gi] = !sel_hit ? duty_reg[gi]                   :
                                  ramp_up  ? (up_sat ? 8'd255 : up_sum[7:0]) :
                                             (dn_sat ? 8'd0
                                                     : duty_reg[gi] - STEP8);
        end
    endgenerate

    assign advance = |chan_done;
    assign tick    = (cnt_reg == CNT_MAX);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        cnt_next   = cnt_reg;
        duty_next  = duty_reg;
        phase_next = phase_reg;
        wrap_next  = 1'b0;

        if (restart) begin
            // restart wins over en and over a tick on the same edge.
            cnt_next   = '0;
            duty_next  = DUTY_RST;
            phase_next = PH_R_G_UP;
        end else if (en) begin
            if (tick) begin
                cnt_next = '0;
                if (!phase_legal) begin
                    duty_next  = DUTY_RST;
                    phase_next = PH_R_G_UP;
                end else begin
                    duty_next = chan_val;
                    if (advance) begin
                        case (phase_reg)
                            PH_R_G_UP: phase_next = PH_G_R_DN;
                            PH_G_R_DN: phase_next = PH_G_B_UP;
                            PH_G_B_UP: phase_next = PH_B_G_DN;
                            PH_B_G_DN: phase_next = PH_B_R_UP;
                            PH_B_R_UP: phase_next = PH_R_B_DN;
                            default:   phase_next = PH_R_G_UP;
                        endcase
                        wrap_next = (phase_reg == PH_R_B_DN);
                    end
                end
            end else begin
                cnt_next = cnt_reg + CNT_W'(1);
            end
        end
        // en low: everything holds and wrap stays low (its default).
    end

    // ------------------------------------------------------------------------
    // State register. The reset is asynchronous, so the outputs snap to the
    // reset colour as soon as nrst falls, without waiting for clk.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_reg   <= '0;
            duty_reg  <= DUTY_RST;
            phase_reg <= PH_R_G_UP;
            wrap_reg  <= 1'b0;
        end else begin
            cnt_reg   <= cnt_next;
            duty_reg  <= duty_next;
            phase_reg <= phase_next;
            wrap_reg  <= wrap_next;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: direct flop outputs.
    // ------------------------------------------------------------------------
    assign duty_r = duty_reg[CH_R];
    assign duty_g = duty_reg[CH_G];
    assign duty_b = duty_reg[CH_B];
    assign phase  = phase_reg;
    assign wrap   = wrap_reg;

endmodule

// File: tb/tb_rgb_hue_fader.sv
// ----------------------------------------------------------------------------
// tb_rgb_hue_fader
//
// Two faders share the same en/restart/nrst stimulus:
//   slow : TICK_DIV=4, STEP=1   (full-wheel timing, hold, restart, reset)
//   fast : TICK_DIV=1, STEP=100 (tick on every cycle, saturating steps)
//
// The stimulus process steps a behavioural hue-wheel model for each fader.
// For every clock edge it pushes the expected outputs into a per-fader queue.
// A separate monitor samples the outputs shortly after each rising clk edge,
// or after an asynchronous reset edge. It pops one expectation per fader and
// compares.
// ----------------------------------------------------------------------------
module tb_rgb_hue_fader;

    localparam int S_DIV  = 4;
    localparam int S_STEP = 1;
    localparam int F_DIV  = 1;
    localparam int F_STEP = 100;

    logic       clk     = 1'b0;
    logic       nrst    = 1'b0;
    logic       en      = 1'b0;
    logic       restart = 1'b0;

    logic [7:0] s_r, s_g, s_b, f_r, f_g, f_b;
    logic [2:0] s_ph, f_ph;
    logic       s_wrap, f_wrap;

    rgb_hue_fader #(.TICK_DIV(S_DIV), .STEP(S_STEP)) dut_slow (
        .clk(clk), .nrst(nrst), .en(en), .restart(restart),
        .duty_r(s_r), .duty_g(s_g), .duty_b(s_b), .phase(s_ph), .wrap(s_wrap)
    );

    rgb_hue_fader #(.TICK_DIV(F_DIV), .STEP(F_STEP)) dut_fast (
        .clk(clk), .nrst(nrst), .en(en), .restart(restart),
        .duty_r(f_r), .duty_g(f_g), .duty_b(f_b), .phase(f_ph), .wrap(f_wrap)
    );

    always #5 clk = ~clk;

    // Model state: position in the prescaler, the wheel phase and the colour.
    typedef struct packed {
        int   cnt;
        int   ph;
        int   r;
        int   g;
        int   b;
        logic wrap;
    } ms_t;

    ms_t s_mod, f_mod;
    ms_t s_q[$];
    ms_t f_q[$];

    int total = 0;
    int bad   = 0;
    int s_wraps_seen = 0;

    function automatic ms_t reset_state();
        ms_t z;
        z.cnt = 0; z.ph = 0; z.r = 255; z.g = 0; z.b = 0; z.wrap = 1'b0;
        return z;
    endfunction

    // Hue wheel: phase p ramps channel wheel_ch[p] (0=R, 1=G, 2=B).
    // Even phases go up and odd phases go down. The channel saturates at its
    // rail, and reaching the rail ends the phase.
    function automatic ms_t model_next(ms_t s, int div, int stp,
                                       logic rst_n, logic e, logic rs);
        ms_t n;
        int  d[3];
        int  wheel_ch[6];
        int  ch;
        int  v;
        bit  adv;
        wheel_ch = '{1, 0, 2, 1, 0, 2};
        n = s;
        n.wrap = 1'b0;
        if (!rst_n || rs) return reset_state();
        if (!e) return n;
        if (s.cnt < div - 1) begin
            n.cnt = s.cnt + 1;
            return n;
        end
        n.cnt = 0;
        d[0] = s.r; d[1] = s.g; d[2] = s.b;
        ch = wheel_ch[s.ph];
        if ((s.ph % 2) == 0) begin
            v = d[ch] + stp;
            if (v > 255) v = 255;
            adv = (v == 255);
        end else begin
            v = d[ch] - stp;
            if (v < 0) v = 0;
            adv = (v == 0);
        end
        d[ch] = v;
        n.r = d[0]; n.g = d[1]; n.b = d[2];
        if (adv) begin
            n.ph   = (s.ph + 1) % 6;
            n.wrap = (s.ph == 5);
        end
        return n;
    endfunction

    function automatic int mid_count(int r, int g, int b);
        return int'(r > 0 && r < 255) + int'(g > 0 && g < 255)
             + int'(b > 0 && b < 255);
    endfunction

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s t=%0t got=%0d want=%0d", name, $time, got, want);
        end
    endtask

    task automatic bound_fail(input string name);
        total++;
        bad++;
        $display("FAIL bound_%s t=%0t got=expired want=reached", name, $time);
    endtask

    // Applies inputs for the next rising edge, records the expected outputs
    // after that edge, and returns just after the edge.
    task automatic step(input logic e, input logic rs);
        en      = e;
        restart = rs;
        s_mod = model_next(s_mod, S_DIV, S_STEP, nrst, e, rs);
        f_mod = model_next(f_mod, F_DIV, F_STEP, nrst, e, rs);
        s_q.push_back(s_mod);
        f_q.push_back(f_mod);
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------------
    initial begin
        ms_t e;
        forever begin
            @(posedge clk or negedge nrst);
            #2;
            if (s_q.size() > 0) begin
                e = s_q.pop_front();
                chk("slow.duty_r", int'(s_r), e.r);
                chk("slow.duty_g", int'(s_g), e.g);
                chk("slow.duty_b", int'(s_b), e.b);
                chk("slow.phase",  int'(s_ph), e.ph);
                chk("slow.wrap",   int'(s_wrap), int'(e.wrap));
                chk("slow.one_ramping",
                    int'(mid_count(int'(s_r), int'(s_g), int'(s_b)) <= 1), 1);
                if (s_wrap) begin
                    s_wraps_seen++;
                    $display("slow wheel wrap #%0d t=%0t", s_wraps_seen, $time);
                end
            end
            if (f_q.size() > 0) begin
                e = f_q.pop_front();
                chk("fast.duty_r", int'(f_r), e.r);
                chk("fast.duty_g", int'(f_g), e.g);
                chk("fast.duty_b", int'(f_b), e.b);
                chk("fast.phase",  int'(f_ph), e.ph);
                chk("fast.wrap",   int'(f_wrap), int'(e.wrap));
                chk("fast.one_ramping",
                    int'(mid_count(int'(f_r), int'(f_g), int'(f_b)) <= 1), 1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        int guard;
        s_mod = reset_state();
        f_mod = reset_state();

        // Reset held over a few edges, then released between edges.
        repeat (3) step(1'b0, 1'b0);
        nrst = 1'b1;
        $display("reset released t=%0t", $time);

        // One full wheel on the slow fader, plus a little slack.
        repeat (S_DIV * 1530 + 20) step(1'b1, 1'b0);
        $display("full wheel run done t=%0t slow_wraps=%0d", $time, s_wraps_seen);

        // Freeze mid-ramp at G=37, partway through a prescaler period.
        guard = 0;
        while (!(s_mod.ph == 0 && s_mod.g == 37 && s_mod.cnt == 1) && guard < 2000) begin
            step(1'b1, 1'b0);
            guard++;
        end
        if (guard >= 2000) bound_fail("reach_g37");
        repeat (50) step(1'b0, 1'b0);
        repeat (8) step(1'b1, 1'b0);
        $display("enable hold of 50 cycles done t=%0t", $time);

        // Random enable with occasional restarts.
        for (int i = 0; i < 400; i++)
            step(1'(($urandom % 4) != 0), 1'(($urandom % 80) == 0));
        $display("random en/restart burst done t=%0t", $time);

        // Restart on a tick edge while the slow fader is in phase 3.
        guard = 0;
        while (!(s_mod.ph == 3 && s_mod.g < 128 && s_mod.cnt == S_DIV - 1)
               && guard < 10000) begin
            step(1'b1, 1'b0);
            guard++;
        end
        if (guard >= 10000) bound_fail("reach_phase3");
        step(1'b1, 1'b1);
        repeat (20) step(1'b1, 1'b0);
        $display("restart on phase-3 tick done t=%0t", $time);

        // Asynchronous reset between edges while in phase 4.
        guard = 0;
        while (!(s_mod.ph == 4 && s_mod.r > 60) && guard < 10000) begin
            step(1'b1, 1'b0);
            guard++;
        end
        if (guard >= 10000) bound_fail("reach_phase4");
        step(1'b1, 1'b0);
        #2;
        nrst  = 1'b0;
        s_mod = reset_state();
        f_mod = reset_state();
        s_q.push_back(s_mod);
        f_q.push_back(f_mod);
        repeat (2) step(1'b1, 1'b0);
        nrst = 1'b1;
        repeat (30) step(1'b1, 1'b0);
        $display("async reset in phase 4 done t=%0t", $time);

        for (int i = 0; i < 300; i++)
            step(1'(($urandom % 3) != 0), 1'(($urandom % 100) == 0));
        $display("final random burst done t=%0t", $time);

        // Let the monitor drain the queues.
        repeat (3) @(posedge clk);
        #3;
        chk("slow.queue_drained", s_q.size(), 0);
        chk("fast.queue_drained", f_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
